// File: rtl/uart_frame_rx_if.sv
// Byte-stream bundle between uart_frame_rx and its RX FIFO, TX FIFO and payload sink.
// The slave modport is the receiver's view; master is the surrounding logic's view.
interface uart_frame_rx_if;
  logic [7:0] i_rx_data;
  logic       i_rx_rdy;
  logic       o_rx_req;
  logic       i_tx_rdy;
  logic [7:0] o_tx_data;
  logic       o_tx_req;
  logic [7:0] o_data;
  logic       o_valid;
  logic       o_last;
  logic       i_ready;
  logic       o_crc_err;
  logic       o_len_err;
  logic       o_timeout;

  modport slave (
    input  i_rx_data, i_rx_rdy, i_tx_rdy, i_ready,
    output o_rx_req, o_tx_data, o_tx_req, o_data, o_valid, o_last,
           o_crc_err, o_len_err, o_timeout
  );

  modport master (
    output i_rx_data, i_rx_rdy, i_tx_rdy, i_ready,
    input  o_rx_req, o_tx_data, o_tx_req, o_data, o_valid, o_last,
           o_crc_err, o_len_err, o_timeout
  );
endinterface

// File: rtl/uart_frame_rx.sv
// Frame parser (SOF, LEN, payload, CHK): buffers payload, streams it out one cycle after CHK, answers ACK/NAK.
// RX pops stop during drain and response, so RX FIFO backpressure reaches the UART; o_data holds while i_ready=0.
module uart_frame_rx #(
  parameter int         MaxPayload    = 16,
  parameter logic [7:0] SofByte       = 8'h7E,
  parameter logic [7:0] AckByte       = 8'h06,
  parameter logic [7:0] NakByte       = 8'h15,
  parameter int         TimeoutCycles = 50_000
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  uart_frame_rx_if.slave bus
);
  localparam int IdxW = $clog2(MaxPayload + 1);
  localparam int BufW = (MaxPayload > 1) ? $clog2(MaxPayload) : 1;
  localparam int TmoW = $clog2(TimeoutCycles);
  localparam logic [7:0]      MaxLen  = 8'(MaxPayload);
  localparam logic [IdxW-1:0] IdxOne  = IdxW'(1);
  localparam logic [TmoW-1:0] TmoOne  = TmoW'(1);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TimeoutCycles - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN, S_PAYLOAD, S_CHK, S_DRAIN, S_RESP
  } state_t;

  state_t          r_state;
  logic [IdxW-1:0] r_len;
  logic [IdxW-1:0] r_idx;
  logic [7:0]      r_sum;
  logic [TmoW-1:0] r_tmo;
  logic [7:0]      r_buf [MaxPayload];
  logic [7:0]      r_data;
  logic            r_valid;
  logic            r_last;
  logic [7:0]      r_tx_data;
  logic            r_crc_err;
  logic            r_len_err;
  logic            r_timeout;

  logic            w_pop_state;
  logic            w_pop;
  logic            w_tmo_hit;
  logic            w_len_ok;
  logic            w_at_end;
  logic [7:0]      w_sum_next;
  logic [IdxW-1:0] w_idx_inc;
  logic [IdxW-1:0] w_len_m1;

  assign w_pop_state = (r_state == S_IDLE) || (r_state == S_LEN) ||
                       (r_state == S_PAYLOAD) || (r_state == S_CHK);
  // Gating with reset keeps the RX FIFO intact while the block is held in reset.
  assign w_pop      = bus.i_rx_rdy & i_rst_n & w_pop_state;
  assign w_tmo_hit  = (r_tmo == TmoLast) & ~w_pop;
  assign w_len_ok   = (bus.i_rx_data != 8'h00) && (bus.i_rx_data <= MaxLen);
  assign w_sum_next = r_sum + bus.i_rx_data;
  assign w_idx_inc  = r_idx + IdxOne;
  assign w_len_m1   = r_len - IdxOne;
  assign w_at_end   = (r_idx == w_len_m1);

  assign bus.o_rx_req  = w_pop;
  assign bus.o_tx_req  = (r_state == S_RESP) & bus.i_tx_rdy;
  assign bus.o_tx_data = r_tx_data;
  assign bus.o_data    = r_data;
  assign bus.o_valid   = r_valid;
  assign bus.o_last    = r_last;
  assign bus.o_crc_err = r_crc_err;
  assign bus.o_len_err = r_len_err;
  assign bus.o_timeout = r_timeout;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state   <= S_IDLE;
      r_len     <= '0;
      r_idx     <= '0;
      r_sum     <= '0;
      r_tmo     <= '0;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_last    <= 1'b0;
      r_tx_data <= '0;
      r_crc_err <= 1'b0;
      r_len_err <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_crc_err <= 1'b0;
      r_len_err <= 1'b0;
      r_timeout <= 1'b0;

      if (w_pop || !w_pop_state || r_state == S_IDLE) begin
        r_tmo <= '0;
      end else begin
        r_tmo <= r_tmo + TmoOne;
      end

      case (r_state)
        S_IDLE: begin
          if (w_pop && bus.i_rx_data == SofByte) begin
            r_sum   <= '0;
            r_state <= S_LEN;
          end
        end

        S_LEN: begin
          if (w_pop) begin
            if (w_len_ok) begin
              r_len   <= bus.i_rx_data[IdxW-1:0];
              r_sum   <= bus.i_rx_data;
              r_idx   <= '0;
              r_state <= S_PAYLOAD;
            end else begin
              r_len_err <= 1'b1;
              r_tx_data <= NakByte;
              r_state   <= S_RESP;
            end
          end else if (w_tmo_hit) begin
            r_timeout <= 1'b1;
            r_tmo     <= '0;
            r_state   <= S_IDLE;
          end
        end

        S_PAYLOAD: begin
          if (w_pop) begin
            r_buf[r_idx[BufW-1:0]] <= bus.i_rx_data;
            r_sum                  <= w_sum_next;
            if (w_at_end) begin
              r_idx   <= '0;
              r_state <= S_CHK;
            end else begin
              r_idx <= w_idx_inc;
            end
          end else if (w_tmo_hit) begin
            r_timeout <= 1'b1;
            r_tmo     <= '0;
            r_idx     <= '0;
            r_state   <= S_IDLE;
          end
        end

        S_CHK: begin
          if (w_pop) begin
            if (w_sum_next == 8'h00) begin
              // Present buffer[0] straight away so the first byte leaves one cycle after CHK.
              r_valid <= 1'b1;
              r_data  <= r_buf[0];
              r_last  <= (r_len == IdxOne);
              r_idx   <= '0;
              r_state <= S_DRAIN;
            end else begin
              r_crc_err <= 1'b1;
              r_tx_data <= NakByte;
              r_state   <= S_RESP;
            end
          end else if (w_tmo_hit) begin
            r_timeout <= 1'b1;
            r_tmo     <= '0;
            r_state   <= S_IDLE;
          end
        end

        S_DRAIN: begin
          if (r_valid && bus.i_ready) begin
            if (r_last) begin
              r_valid   <= 1'b0;
              r_last    <= 1'b0;
              r_idx     <= '0;
              r_tx_data <= AckByte;
              r_state   <= S_RESP;
            end else begin
              r_idx  <= w_idx_inc;
              r_data <= r_buf[w_idx_inc[BufW-1:0]];
              r_last <= (w_idx_inc == w_len_m1);
            end
          end
        end

        S_RESP: begin
          if (bus.i_tx_rdy) begin
            r_state <= S_IDLE;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_frame_rx.sv
// Directed bench for uart_frame_rx: an RX FIFO model feeds bytes, a scoreboard checks payload and response bytes.
module tb_uart_frame_rx;
  localparam int Tmo = 40;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_frame_rx_if bus ();

  uart_frame_rx #(
    .MaxPayload   (16),
    .SofByte      (8'h7E),
    .AckByte      (8'h06),
    .NakByte      (8'h15),
    .TimeoutCycles(Tmo)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int n_crc = 0, n_len = 0, n_to = 0, n_tx = 0, n_dat = 0;

  logic [7:0] rx_q[$];
  logic [8:0] exp_dat[$];
  logic [7:0] exp_tx[$];

  logic       pop_pend = 1'b0;
  logic       rand_rdy = 1'b0;
  logic       tx_en    = 1'b1;
  logic       prev_vld = 1'b0, prev_rdy = 1'b0;
  logic [8:0] prev_dl  = '0;
  logic       prev_crc = 1'b0, prev_len = 1'b0, prev_to = 1'b0, prev_tx = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // RX FIFO / sink / TX FIFO model: inputs change only 1 time unit after the edge.
  always @(posedge clk) begin
    #1;
    if (pop_pend && rx_q.size() > 0) void'(rx_q.pop_front());
    pop_pend       = 1'b0;
    bus.i_rx_rdy   = (rx_q.size() > 0);
    bus.i_rx_data  = (rx_q.size() > 0) ? rx_q[0] : 8'h00;
    bus.i_ready    = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    bus.i_tx_rdy   = tx_en;
  end

  always @(negedge clk) begin
    pop_pend = bus.o_rx_req;
    if (rst_n === 1'b1) begin
      if (prev_vld && !prev_rdy) begin
        chk("hold_valid", 32'(bus.o_valid), 32'd1);
        chk("hold_data", 32'({bus.o_last, bus.o_data}), 32'(prev_dl));
      end
      if (bus.o_valid && bus.i_ready) begin
        n_dat++;
        chk("data_expected", 32'(exp_dat.size() > 0), 32'd1);
        if (exp_dat.size() > 0) chk("data_last", 32'({bus.o_last, bus.o_data}), 32'(exp_dat.pop_front()));
      end
      if (bus.o_tx_req) begin
        n_tx++;
        chk("tx_when_rdy", 32'(bus.i_tx_rdy), 32'd1);
        chk("tx_one_cycle", 32'(prev_tx), 32'd0);
        chk("tx_expected", 32'(exp_tx.size() > 0), 32'd1);
        if (exp_tx.size() > 0) chk("tx_data", 32'(bus.o_tx_data), 32'(exp_tx.pop_front()));
      end
      if (bus.o_crc_err) begin n_crc++; chk("crc_pulse", 32'(prev_crc), 32'd0); end
      if (bus.o_len_err) begin n_len++; chk("len_pulse", 32'(prev_len), 32'd0); end
      if (bus.o_timeout) begin n_to++;  chk("to_pulse",  32'(prev_to),  32'd0); end
    end
    prev_vld = bus.o_valid;
    prev_rdy = bus.i_ready;
    prev_dl  = {bus.o_last, bus.o_data};
    prev_crc = bus.o_crc_err;
    prev_len = bus.o_len_err;
    prev_to  = bus.o_timeout;
    prev_tx  = bus.o_tx_req;
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic push(input logic [7:0] b);
    rx_q.push_back(b);
  endtask

  task automatic send_good(input int len, input logic [7:0] base);
    logic [7:0] s;
    logic [7:0] b;
    s = 8'(len);
    push(8'h7E);
    push(8'(len));
    for (int i = 0; i < len; i++) begin
      b = base + 8'(i * 37);
      push(b);
      s = s + b;
      exp_dat.push_back({(i == len - 1), b});
    end
    push(8'h00 - s);
    exp_tx.push_back(8'h06);
  endtask

  task automatic settle(input string tag, input int budget);
    int k;
    k = 0;
    while ((rx_q.size() + exp_dat.size() + exp_tx.size()) != 0 && k < budget) begin
      cyc(1);
      k++;
    end
    chk(tag, 32'(rx_q.size() + exp_dat.size() + exp_tx.size()), 32'd0);
    cyc(4);
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_valid"},   32'(bus.o_valid),   32'd0);
    chk({tag, "_last"},    32'(bus.o_last),    32'd0);
    chk({tag, "_tx_req"},  32'(bus.o_tx_req),  32'd0);
    chk({tag, "_crc"},     32'(bus.o_crc_err), 32'd0);
    chk({tag, "_len"},     32'(bus.o_len_err), 32'd0);
    chk({tag, "_to"},      32'(bus.o_timeout), 32'd0);
    chk({tag, "_tx_data"}, 32'(bus.o_tx_data), 32'd0);
    chk({tag, "_data"},    32'(bus.o_data),    32'd0);
    chk({tag, "_rx_req"},  32'(bus.o_rx_req),  32'd0);
  endtask

  initial begin
    int k;
    rst_n = 1'b0;
    cyc(3);
    chk_zero_outputs("reset");
    rst_n = 1'b1;
    cyc(2);

    // Reference good frame from the plan
    push(8'h7E); push(8'h03); push(8'h11); push(8'h22); push(8'h33); push(8'h97);
    exp_dat.push_back({1'b0, 8'h11});
    exp_dat.push_back({1'b0, 8'h22});
    exp_dat.push_back({1'b1, 8'h33});
    exp_tx.push_back(8'h06);
    settle("good_frame_done", 200);
    chk("good_ndat", 32'(n_dat), 32'd3);
    chk("good_ntx",  32'(n_tx),  32'd1);

    // Bad checksum
    push(8'h7E); push(8'h02); push(8'hAA); push(8'hBB); push(8'h00);
    exp_tx.push_back(8'h15);
    settle("crc_frame_done", 200);
    chk("crc_ncrc", 32'(n_crc), 32'd1);
    chk("crc_ndat", 32'(n_dat), 32'd3);

    // LEN 0 and LEN 17, then a one-byte frame
    push(8'h7E); push(8'h00);
    push(8'h7E); push(8'h11);
    push(8'h7E); push(8'h01); push(8'h5A); push(8'hA5);
    exp_tx.push_back(8'h15);
    exp_tx.push_back(8'h15);
    exp_tx.push_back(8'h06);
    exp_dat.push_back({1'b1, 8'h5A});
    settle("len_frames_done", 300);
    chk("len_nlen", 32'(n_len), 32'd2);
    chk("len_ntx",  32'(n_tx),  32'd5);

    // Garbage ahead of a frame
    push(8'h00); push(8'hFF); push(8'h12);
    push(8'h7E); push(8'h01); push(8'h5A); push(8'hA5);
    exp_dat.push_back({1'b1, 8'h5A});
    exp_tx.push_back(8'h06);
    settle("garbage_done", 200);
    chk("garbage_ncrc", 32'(n_crc), 32'd1);
    chk("garbage_nlen", 32'(n_len), 32'd2);
    chk("garbage_ndat", 32'(n_dat), 32'd5);

    // Inter-byte timeout mid-payload, then recovery
    push(8'h7E); push(8'h02); push(8'h11);
    settle("to_bytes_popped", 100);
    cyc(Tmo + 10);
    chk("to_nto", 32'(n_to), 32'd1);
    chk("to_ntx", 32'(n_tx), 32'd6);
    send_good(4, 8'h30);
    settle("to_recover_done", 200);
    chk("to_recover_ndat", 32'(n_dat), 32'd9);

    // Random downstream stalls plus a blocked TX FIFO
    rand_rdy = 1'b1;
    tx_en    = 1'b0;
    send_good(12, 8'hC1);
    k = 0;
    while (exp_dat.size() != 0 && k < 500) begin cyc(1); k++; end
    chk("bp_drained", 32'(exp_dat.size()), 32'd0);
    cyc(20);
    chk("bp_ack_held_ntx", 32'(n_tx), 32'd7);
    chk("bp_ack_pending",  32'(exp_tx.size()), 32'd1);
    tx_en    = 1'b1;
    rand_rdy = 1'b0;
    settle("bp_done", 100);
    chk("bp_ntx",  32'(n_tx),  32'd8);
    chk("bp_ndat", 32'(n_dat), 32'd21);

    // Reset after the second payload byte
    push(8'h7E); push(8'h04); push(8'h01); push(8'h02);
    settle("rst_bytes_popped", 100);
    rst_n = 1'b0;
    cyc(1);
    chk_zero_outputs("midrst");
    cyc(1);
    rst_n = 1'b1;
    cyc(Tmo + 10);
    chk("midrst_nto", 32'(n_to), 32'd1);
    chk("midrst_ntx", 32'(n_tx), 32'd8);

    // Maximum-length frame
    send_good(16, 8'h07);
    settle("maxlen_done", 300);
    chk("maxlen_ndat", 32'(n_dat), 32'd37);
    chk("maxlen_ntx",  32'(n_tx),  32'd9);
    chk("final_ncrc",  32'(n_crc), 32'd1);
    chk("final_nlen",  32'(n_len), 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not complete, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end
endmodule
